ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters:
  - CPU port: fetch, load and store traffic from the datapath under control_unit sequencing.
  - Debug/loader port: program download and memory inspection.
- Grants at most one access per cycle, with round-robin fairness bounded by a burst limit.
- Supports an exclusive debug lock.
- Returns read data with fixed one-cycle latency to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 8: RAM word address width.
- DATA_WIDTH, 16: RAM word width.
- MAX_BURST, 4: maximum consecutive grants to one owner while the other is requesting (legal range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_WIDTH  CPU word address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_WIDTH  CPU read data
- dbg_req  in  1  debug access request, held until dbg_gnt
- dbg_we  in  1  debug write / read
- dbg_addr  in  ADDR_WIDTH  debug word address
- dbg_wdata  in  DATA_WIDTH  debug write data
- dbg_lock  in  1  exclusive ownership for debug port
- dbg_gnt  out  1  debug access accepted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_WIDTH  debug read data
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_we  out  1  RAM write strobe
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM synchronous read data, valid the cycle after address
- cpu_blocked  out  1  cpu_req high and not granted this cycle (stall hint for the control unit)

Behaviour:
- Reset (rst_n low, asynchronous):
  - last_owner = OWNER_DBG, so the CPU wins the first tie.
  - burst_cnt = 0; rd_pending = 0.
  - cpu_rvalid = dbg_rvalid = 0.
  - All gnt, ram_we and cpu_blocked are forced to 0 while reset is asserted.
  - ram_addr and ram_wdata are don't-care, but drive 0.
- Handshake:
  - A requester raises req with stable we/addr/wdata and holds them until gnt.
  - gnt is combinational and one-cycle. The access is performed in the gnt cycle.
  - req may stay high for back-to-back accesses.
  - Dropping req before gnt is legal and cancels the request.
- Arbitration (combinational, evaluated each cycle):
  - dbg_lock = 1: only the debug port is eligible; cpu_gnt = 0.
  - Only one eligible req: grant it.
  - Both requesting, with burst_cnt < MAX_BURST: grant the owner opposite last_owner, except that the current owner keeps the bus if it was granted the previous cycle (burst continuation).
  - Both requesting, with burst_cnt == MAX_BURST: grant the non-last owner.
  - Neither requesting: no grant.
- RAM mux:
  - ram_addr, ram_we and ram_wdata come from the granted port.
  - With no grant: ram_we = 0 and ram_addr holds the CPU address.
- State update (registered):
  - On a grant: last_owner = granted port.
  - burst_cnt = 1 if the owner changed, or if the previous cycle had no grant; otherwise burst_cnt+1, saturating at MAX_BURST.
  - With no grant: burst_cnt = 0.
- Read return:
  - A granted read sets a registered rvalid pulse for exactly one cycle, on the granting port only, in the next cycle.
  - xxx_rdata = ram_rdata (combinational passthrough), meaningful only while xxx_rvalid.
  - Writes produce no rvalid.
- Back-to-back behaviour:
  - A read grant and an rvalid for the previous read can coincide.
  - Ports may differ between the two, e.g. dbg_rvalid while cpu_gnt.
- Lock timing:
  - dbg_lock rising while the CPU is mid-burst: the CPU loses the bus the same cycle.
  - A pending CPU rvalid from the previous cycle is still delivered.
- Reset mid-transfer: a pending rvalid is discarded and not delivered after reset release.
- cpu_blocked = cpu_req & ~cpu_gnt.

Decomposition:
- k_and_s_pkg: add mem_owner_t enum {OWNER_CPU, OWNER_DBG}.
- k_and_s_pkg: add constant DEFAULT_MAX_BURST = 4.
- No sub-module. The arbitration decision is a single always_comb block; counters and rvalid live in one always_ff.

Test Plan:
- CPU-only reads at addr 0x05 then 0x06 with RAM holding 0x1234 and 0xBEEF → cpu_gnt high 2 consecutive cycles; cpu_rvalid in the following 2 cycles with rdata 0x1234 then 0xBEEF; dbg_rvalid stays 0.
- Both ports requesting continuously from reset, MAX_BURST=4 → grant pattern CPU,CPU,CPU,CPU,DBG,DBG,DBG,DBG,CPU…; never more than 4 consecutive grants to one port.
- dbg_lock=1 with CPU and DBG both requesting for 10 cycles → dbg_gnt every cycle; cpu_gnt 0 and cpu_blocked 1 throughout; release lock → CPU granted next cycle.
- DBG write 0x00AA to addr 0x10, then CPU read of 0x10 the next cycle → ram_we high only in the DBG grant cycle; cpu_rdata = 0x00AA with cpu_rvalid; no dbg_rvalid.
- CPU read granted, then rst_n pulsed low the following cycle → cpu_rvalid 0 during and after reset; first post-reset tie is granted to CPU.
- Request withdrawal: dbg_req high one cycle while the CPU holds the bus mid-burst, then dropped → no dbg_gnt, no dbg_rvalid, and the CPU burst continues uninterrupted.

Source files
------------

// File: rtl/k_and_s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : k_and_s_pkg
// Purpose  : Shared types and constants for the RAM port arbiter: owner
//            encoding, default burst limit and the burst counter width.
// Revision : 1.0 - initial release
// ============================================================================
package k_and_s_pkg;

    // Identifies which requester currently owns (or last owned) the RAM port.
    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } mem_owner_t;

    // Default number of back-to-back grants one owner may take while the
    // other port is waiting.
    localparam int DEFAULT_MAX_BURST = 4;

    // Burst counter width; large enough for the maximum legal burst of 15.
    localparam int BURST_CNT_WIDTH = 4;

    // Returns the owner opposite to the one given.
    function automatic mem_owner_t other_owner(input mem_owner_t owner);
        return (owner == OWNER_CPU) ? OWNER_DBG : OWNER_CPU;
    endfunction

endpackage : k_and_s_pkg
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_if
// Purpose  : Bundles the CPU port, debug port and RAM-side signals of the
//            RAM port arbiter. The slave modport is the arbiter view; the
//            master modport is the view of the surrounding requesters + RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    // CPU port
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_blocked;

    // Debug / loader port
    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_lock;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [DATA_WIDTH-1:0] dbg_rdata;

    // RAM side
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_blocked,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    // Requesters and RAM view
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_blocked,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface : ram_port_arbiter_if
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares one single-port RAM between the CPU and the debug/loader
//            port. One access per cycle, round-robin with a burst limit,
//            exclusive debug lock, one-cycle read return to the issuer.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import k_and_s_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ram_port_arbiter_if.slave  bus
);

    localparam logic [BURST_CNT_WIDTH-1:0] C_MAX_BURST = BURST_CNT_WIDTH'(MAX_BURST);
    localparam logic [BURST_CNT_WIDTH-1:0] C_ONE       = BURST_CNT_WIDTH'(1);

    // Registered arbitration state
    mem_owner_t                 r_last_owner;
    logic [BURST_CNT_WIDTH-1:0] r_burst_cnt;   // 0 means "no grant last cycle"
    logic                       r_cpu_rvalid;
    logic                       r_dbg_rvalid;

    // Combinational decision
    logic                  w_cpu_elig;
    logic                  w_dbg_elig;
    mem_owner_t            w_winner;
    logic                  w_cpu_gnt;
    logic                  w_dbg_gnt;
    logic                  w_any_gnt;
    mem_owner_t            w_gnt_owner;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic                  w_ram_we;

    // Arbitration and RAM mux; every grant and strobe is held low in reset.
    always_comb begin
        w_cpu_elig  = bus.cpu_req & ~bus.dbg_lock;
        w_dbg_elig  = bus.dbg_req;
        w_winner    = OWNER_CPU;
        w_cpu_gnt   = 1'b0;
        w_dbg_gnt   = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        w_ram_we    = 1'b0;
        if (rst_n) begin
            if (w_cpu_elig && w_dbg_elig) begin
                // Keep the bus while the running burst is below the limit;
                // otherwise (limit hit or idle last cycle) hand it over.
                if ((r_burst_cnt != '0) && (r_burst_cnt < C_MAX_BURST)) begin
                    w_winner = r_last_owner;
                end else begin
                    w_winner = other_owner(r_last_owner);
                end
                w_cpu_gnt = (w_winner == OWNER_CPU);
                w_dbg_gnt = (w_winner == OWNER_DBG);
            end else begin
                w_cpu_gnt = w_cpu_elig;
                w_dbg_gnt = w_dbg_elig;
            end

            // Debug drives the RAM only when granted; CPU address otherwise.
            if (w_dbg_gnt) begin
                w_ram_addr  = bus.dbg_addr;
                w_ram_wdata = bus.dbg_wdata;
                w_ram_we    = bus.dbg_we;
            end else begin
                w_ram_addr  = bus.cpu_addr;
                w_ram_wdata = bus.cpu_wdata;
                w_ram_we    = w_cpu_gnt & bus.cpu_we;
            end
        end
    end

    assign w_any_gnt   = w_cpu_gnt | w_dbg_gnt;
    assign w_gnt_owner = w_dbg_gnt ? OWNER_DBG : OWNER_CPU;

    // Burst tracking, last owner and the one-cycle read-valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= OWNER_DBG;
            r_burst_cnt  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~bus.cpu_we;
            r_dbg_rvalid <= w_dbg_gnt & ~bus.dbg_we;
            if (w_any_gnt) begin
                r_last_owner <= w_gnt_owner;
                if ((w_gnt_owner != r_last_owner) || (r_burst_cnt == '0)) begin
                    r_burst_cnt <= C_ONE;
                end else if (r_burst_cnt < C_MAX_BURST) begin
                    r_burst_cnt <= r_burst_cnt + C_ONE;
                end
            end else begin
                r_burst_cnt <= '0;
            end
        end
    end

    assign bus.cpu_gnt     = w_cpu_gnt;
    assign bus.dbg_gnt     = w_dbg_gnt;
    assign bus.cpu_blocked = bus.cpu_req & ~w_cpu_gnt & rst_n;
    assign bus.ram_addr    = w_ram_addr;
    assign bus.ram_wdata   = w_ram_wdata;
    assign bus.ram_we      = w_ram_we;
    assign bus.cpu_rvalid  = r_cpu_rvalid;
    assign bus.dbg_rvalid  = r_dbg_rvalid;
    // Read data is a passthrough; the rvalid flags tell who owns it.
    assign bus.cpu_rdata   = bus.ram_rdata;
    assign bus.dbg_rdata   = bus.ram_rdata;

endmodule : ram_port_arbiter
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Bench for ram_port_arbiter: directed scenarios with literal
//            expectations, then randomized traffic, all compared each cycle
//            against a streak/queue level model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;
    import k_and_s_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Synchronous RAM, read-before-write, one-cycle read latency.
    logic [DW-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram_mem[bus.ram_addr];
    end

    // Reference model state
    logic [DW-1:0] shadow [256];
    bit            m_last_dbg;    // last granted port is debug
    int            m_streak;      // consecutive grants to m_last_dbg's port
    bit            m_prev_gnt;    // something was granted last cycle
    bit            m_pend_cpu;
    bit            m_pend_dbg;
    logic [DW-1:0] m_pend_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle model comparison, sampled on the falling edge.
    always @(negedge clk) begin : compare
        bit cr, dr, win_dbg, ec, ed, exp_we;
        logic [AW-1:0] ea;
        if (!rst_n) begin
            check("rst_cpu_gnt",     32'(bus.cpu_gnt), 32'd0);
            check("rst_dbg_gnt",     32'(bus.dbg_gnt), 32'd0);
            check("rst_ram_we",      32'(bus.ram_we), 32'd0);
            check("rst_cpu_blocked", 32'(bus.cpu_blocked), 32'd0);
            check("rst_cpu_rvalid",  32'(bus.cpu_rvalid), 32'd0);
            check("rst_dbg_rvalid",  32'(bus.dbg_rvalid), 32'd0);
            check("rst_ram_addr",    32'(bus.ram_addr), 32'd0);
            check("rst_ram_wdata",   32'(bus.ram_wdata), 32'd0);
            m_last_dbg = 1'b1;
            m_streak   = 0;
            m_prev_gnt = 1'b0;
            m_pend_cpu = 1'b0;
            m_pend_dbg = 1'b0;
        end else begin
            cr = bus.cpu_req && !bus.dbg_lock;
            dr = bus.dbg_req;
            win_dbg = 1'b0;
            if (cr && dr)
                win_dbg = (m_prev_gnt && m_streak < MB) ? m_last_dbg : !m_last_dbg;
            ec = cr && !(dr && win_dbg);
            ed = dr && !(cr && !win_dbg);
            exp_we = (ec && bus.cpu_we) || (ed && bus.dbg_we);
            ea = ed ? bus.dbg_addr : bus.cpu_addr;

            check("cpu_gnt",     32'(bus.cpu_gnt), 32'(ec));
            check("dbg_gnt",     32'(bus.dbg_gnt), 32'(ed));
            check("cpu_blocked", 32'(bus.cpu_blocked), 32'(bus.cpu_req && !ec));
            check("ram_we",      32'(bus.ram_we), 32'(exp_we));
            check("ram_addr",    32'(bus.ram_addr), 32'(ea));
            if (ec || ed)
                check("ram_wdata", 32'(bus.ram_wdata), 32'(ed ? bus.dbg_wdata : bus.cpu_wdata));
            check("cpu_rvalid",  32'(bus.cpu_rvalid), 32'(m_pend_cpu));
            check("dbg_rvalid",  32'(bus.dbg_rvalid), 32'(m_pend_dbg));
            if (m_pend_cpu) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_pend_data));
            if (m_pend_dbg) check("dbg_rdata", 32'(bus.dbg_rdata), 32'(m_pend_data));

            // Advance to the next cycle
            m_pend_cpu = ec && !bus.cpu_we;
            m_pend_dbg = ed && !bus.dbg_we;
            if (ec || ed) begin
                if (!exp_we) m_pend_data = shadow[ea];
                else         shadow[ea]  = ed ? bus.dbg_wdata : bus.cpu_wdata;
                if (m_prev_gnt && (ed == m_last_dbg)) m_streak++;
                else                                  m_streak = 1;
                m_last_dbg = ed;
                m_prev_gnt = 1'b1;
            end else begin
                m_prev_gnt = 1'b0;
                m_streak   = 0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cpu_req  = 1'b0;
        bus.dbg_req  = 1'b0;
        bus.dbg_lock = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.dbg_we   = 1'b0;
    endtask

    initial begin : stimulus
        bit gc, gd;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 16'(i) ^ 16'hA5A5;
            shadow[i]  = 16'(i) ^ 16'hA5A5;
        end
        ram_mem[5] = 16'h1234; shadow[5] = 16'h1234;
        ram_mem[6] = 16'hBEEF; shadow[6] = 16'hBEEF;
        idle_inputs();
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_addr = '0; bus.dbg_wdata = '0;
        next_cycle();
        next_cycle();

        // Both ports requesting from reset release: 4 CPU, 4 DBG, 4 CPU.
        rst_n = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h01;
        bus.dbg_req = 1'b1; bus.dbg_addr = 8'h02;
        for (int i = 0; i < 12; i++) begin
            sample();
            check("lit_burst_cpu", 32'(bus.cpu_gnt), 32'(((i / 4) % 2) == 0));
            check("lit_burst_dbg", 32'(bus.dbg_gnt), 32'(((i / 4) % 2) == 1));
            next_cycle();
        end
        idle_inputs();
        sample();
        next_cycle();

        // CPU-only reads of 0x05 and 0x06.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h05;
        sample();
        check("lit_rd_gnt0", 32'(bus.cpu_gnt), 32'd1);
        next_cycle();
        bus.cpu_addr = 8'h06;
        sample();
        check("lit_rd_gnt1",   32'(bus.cpu_gnt), 32'd1);
        check("lit_rd_rv0",    32'(bus.cpu_rvalid), 32'd1);
        check("lit_rd_data0",  32'(bus.cpu_rdata), 32'h1234);
        next_cycle();
        bus.cpu_req = 1'b0;
        sample();
        check("lit_rd_rv1",    32'(bus.cpu_rvalid), 32'd1);
        check("lit_rd_data1",  32'(bus.cpu_rdata), 32'hBEEF);
        check("lit_rd_dbgrv",  32'(bus.dbg_rvalid), 32'd0);
        next_cycle();

        // Debug lock for 10 cycles with both requesting, then release.
        bus.dbg_lock = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h20;
        bus.dbg_req = 1'b1; bus.dbg_addr = 8'h21; bus.dbg_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("lit_lock_dbg", 32'(bus.dbg_gnt), 32'd1);
            check("lit_lock_cpu", 32'(bus.cpu_gnt), 32'd0);
            check("lit_lock_blk", 32'(bus.cpu_blocked), 32'd1);
            next_cycle();
        end
        bus.dbg_lock = 1'b0;
        sample();
        check("lit_unlock_cpu", 32'(bus.cpu_gnt), 32'd1);
        next_cycle();
        idle_inputs();
        sample();
        next_cycle();

        // Debug write 0x00AA to 0x10, CPU reads it back next cycle.
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h10; bus.dbg_wdata = 16'h00AA;
        sample();
        check("lit_wr_gnt", 32'(bus.dbg_gnt), 32'd1);
        check("lit_wr_we",  32'(bus.ram_we), 32'd1);
        next_cycle();
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
        sample();
        check("lit_wr_cpugnt", 32'(bus.cpu_gnt), 32'd1);
        check("lit_wr_we_rd",  32'(bus.ram_we), 32'd0);
        next_cycle();
        bus.cpu_req = 1'b0;
        sample();
        check("lit_wr_rv",    32'(bus.cpu_rvalid), 32'd1);
        check("lit_wr_data",  32'(bus.cpu_rdata), 32'h00AA);
        check("lit_wr_dbgrv", 32'(bus.dbg_rvalid), 32'd0);
        next_cycle();

        // CPU read granted, then reset pulsed before its data returns.
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h07;
        sample();
        check("lit_rst_gnt", 32'(bus.cpu_gnt), 32'd1);
        next_cycle();
        bus.cpu_req = 1'b0;
        rst_n = 1'b0;
        sample();
        check("lit_rst_rv_in", 32'(bus.cpu_rvalid), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        bus.cpu_req = 1'b1; bus.dbg_req = 1'b1;
        sample();
        check("lit_rst_rv_out", 32'(bus.cpu_rvalid), 32'd0);
        check("lit_rst_tie",    32'(bus.cpu_gnt), 32'd1);
        next_cycle();
        idle_inputs();
        sample();
        next_cycle();

        // Debug request withdrawn while the CPU is mid-burst.
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h30;
        sample(); next_cycle();
        sample(); next_cycle();
        bus.dbg_req = 1'b1; bus.dbg_addr = 8'h31;
        sample();
        check("lit_wd_nodbg", 32'(bus.dbg_gnt), 32'd0);
        check("lit_wd_cpu",   32'(bus.cpu_gnt), 32'd1);
        next_cycle();
        bus.dbg_req = 1'b0;
        sample();
        check("lit_wd_cpu2",  32'(bus.cpu_gnt), 32'd1);
        next_cycle();
        sample();
        check("lit_wd_norv",  32'(bus.dbg_rvalid), 32'd0);
        check("lit_wd_cpu3",  32'(bus.cpu_gnt), 32'd1);
        next_cycle();
        idle_inputs();

        // Randomized traffic honouring the hold-until-grant protocol.
        for (int n = 0; n < 3000; n++) begin
            sample();
            gc = bus.cpu_gnt;
            gd = bus.dbg_gnt;
            next_cycle();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            if (gc || !bus.cpu_req || $urandom_range(0, 15) == 0) begin
                bus.cpu_req   = ($urandom_range(0, 3) != 0);
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = 8'($urandom_range(0, 31));
                bus.cpu_wdata = 16'($urandom);
            end
            if (gd || !bus.dbg_req || $urandom_range(0, 15) == 0) begin
                bus.dbg_req   = ($urandom_range(0, 3) != 0);
                bus.dbg_we    = 1'($urandom_range(0, 1));
                bus.dbg_addr  = 8'($urandom_range(0, 31));
                bus.dbg_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 24) == 0) bus.dbg_lock = ~bus.dbg_lock;
        end

        idle_inputs();
        sample();
        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ram_port_arbiter
`default_nettype wire
